ifetch_responder: RTL and testbench

Instruction-fetch responder for the dual-issue core: the memory-side end of the F2 fetch interface. Takes the pipeline's 10-bit fetch address. Returns the 64-bit instruction pair (slot 0 in [63:32], slot 1 in [31:0]) from a single-line pair register. Raises the F2 stall while it refills that register from a 32-bit, one-outstanding-request backing memory.

---
 rtl/ifetch_responder.sv | 112 +++++++++++
 tb/tb_ifetch_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: serves a 64-bit instruction pair from a single-line
// pair register, refilled from a 32-bit backing memory. Optional counter: IFETCH_PERF_CNT_EN.
module ifetch_responder (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [9:0]  iaddr_i,
  output logic [63:0] idata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [7:0]  mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2
  } state_e;

  state_e      state_q;
  logic        valid_q;
  logic [7:0]  tag_q;
  logic [7:0]  fetch_tag_q;
  logic [63:0] pair_q;
  logic        mem_req_q;
  logic [7:0]  mem_addr_q;

  logic [7:0]  word_idx;
  logic        hit;

  assign word_idx = iaddr_i[9:2];
  assign hit      = valid_q && (tag_q == word_idx);

  // Stall is combinational so a hit costs no latency.
  assign stall_o    = reset_i | ~hit | (state_q != IDLE);
  assign idata_o    = pair_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the pair register is reset too, so idata_o reads 0 out of reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      fetch_tag_q <= '0;
      pair_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            fetch_tag_q <= word_idx;
            valid_q     <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= word_idx;
            state_q     <= FETCH0;
          end
        end
        FETCH0: begin
          if (mem_ack_i) begin
            pair_q[63:32] <= mem_rdata_i;
            mem_addr_q    <= fetch_tag_q + 8'd1;
            state_q       <= FETCH1;
          end
        end
        FETCH1: begin
          // The fill always completes under fetch_tag_q, even if iaddr_i moved.
          if (mem_ack_i) begin
            pair_q[31:0] <= mem_rdata_i;
            tag_q        <= fetch_tag_q;
            valid_q      <= 1'b1;
            mem_req_q    <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // NOTE: combinational next-state gets a default first so no latch is inferred.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the fetch line.
module tb_ifetch_responder;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [9:0]  iaddr_i = '0;
  logic [63:0] idata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic [7:0]  mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  ifetch_responder dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .iaddr_i     (iaddr_i),
    .idata_o     (idata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory contents
  logic [31:0] mem [256];

  // Reference model: one cached line plus an in-progress fill of two words.
  bit          m_busy;
  bit          m_valid;
  logic [7:0]  m_tag;
  logic [7:0]  m_ftag;
  logic [7:0]  m_addr;
  int          m_words;
  logic [63:0] m_pair;
  int unsigned m_perf;

  int          lat = 1;
  int          lat_cnt = 0;
  bit          force_ack = 1'b0;
  int          stall_run = 0;
  logic [7:0]  req_log [$];

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_tag   = '0;
    m_ftag  = '0;
    m_addr  = '0;
    m_words = 0;
    m_pair  = '0;
    m_perf  = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, answer as memory, compare, advance model.
  task automatic step(input logic [9:0] a, input logic r);
    logic [7:0]  w;
    bit          hit;
    bit          exp_stall;
    bit          ack;
    logic [31:0] data;
    @(negedge clock_i);
    iaddr_i = a;
    reset_i = r;
    #1;
    if (r) model_reset();
    ack = 1'b0;
    if (force_ack) begin
      ack         = 1'b1;
      lat_cnt     = 0;
      mem_rdata_i = 32'hDEAD_BEEF;
    end else if (r || !mem_req_o) begin
      lat_cnt     = 0;
      mem_rdata_i = $urandom;
    end else begin
      lat_cnt++;
      if (lat_cnt >= lat) begin
        ack         = 1'b1;
        lat_cnt     = 0;
        mem_rdata_i = mem[mem_addr_o];
        req_log.push_back(mem_addr_o);
      end else begin
        mem_rdata_i = $urandom;
      end
    end
    mem_ack_i = ack;

    w         = a[9:2];
    hit       = m_valid && (m_tag == w);
    exp_stall = r || !hit || m_busy;
    check("stall", 64'(stall_o), 64'(exp_stall));
    check("idata", idata_o, m_pair);
    check("mem_req", 64'(mem_req_o), 64'(m_busy));
    check("mem_addr", 64'(mem_addr_o), 64'(m_addr));
`ifdef IFETCH_PERF_CNT_EN
    check("perf", 64'(stall_cycles_o), 64'(m_perf));
`endif
    if (stall_o) stall_run++;

    if (!r) begin
      if (exp_stall && m_perf != 32'hFFFF_FFFF) m_perf++;
      if (!m_busy) begin
        if (!hit) begin
          m_busy  = 1'b1;
          m_ftag  = w;
          m_addr  = w;
          m_words = 0;
          m_valid = 1'b0;
        end
      end else if (ack) begin
        data = force_ack ? mem_rdata_i : mem[m_addr];
        if (m_words == 0) begin
          m_pair[63:32] = data;
          m_words       = 1;
          m_addr        = m_ftag + 8'd1;
        end else begin
          m_pair[31:0] = data;
          m_tag        = m_ftag;
          m_valid      = 1'b1;
          m_busy       = 1'b0;
        end
      end
    end
  endtask

  task automatic run_until_hit(input logic [9:0] a, input int max_cycles);
    int n = 0;
    do begin
      step(a, 1'b0);
      n++;
    end while (stall_o && n < max_cycles);
    check("settle", 64'(stall_o), 64'd0);
  endtask

  task automatic check_reqs(input string tag, input int n,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_count"}, 64'(req_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      check(tag, 64'((i < req_log.size()) ? req_log[i] : 8'hxx), 64'(e[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    model_reset();

    // Reset state
    repeat (3) step(10'h000, 1'b1);
    check("rst_idata", idata_o, 64'd0);
    check("rst_stall", 64'(stall_o), 64'd1);
    check("rst_req", 64'(mem_req_o), 64'd0);

    // Cold fill, L=1
    lat = 1; stall_run = 0; req_log.delete();
    run_until_hit(10'h000, 20);
    check("cold_stall_cycles", 64'(stall_run), 64'd3);
    check("cold_idata", idata_o, 64'h0000_0013_0010_0093);
    check_reqs("cold_req", 2, 8'h00, 8'h01, 8'h00, 8'h00);
`ifdef IFETCH_PERF_CNT_EN
    check("cold_perf", 64'(stall_cycles_o), 64'd3);
`endif

    // Steady hit
    stall_run = 0; req_log.delete();
    repeat (10) step(10'h000, 1'b0);
    check("hit_stall_cycles", 64'(stall_run), 64'd0);
    check("hit_idata", idata_o, 64'h0000_0013_0010_0093);
    check("hit_reqs", 64'(req_log.size()), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("hit_perf", 64'(stall_cycles_o), 64'd3);
`endif

    // Wrap at the top of the word space, L=2
    lat = 2; stall_run = 0; req_log.delete();
    run_until_hit(10'h3FC, 30);
    check("wrap_stall_cycles", 64'(stall_run), 64'd5);
    check("wrap_idata", idata_o, {mem[8'hFF], mem[8'h00]});
    check_reqs("wrap_req", 2, 8'hFF, 8'h00, 8'h00, 8'h00);

    // Address change while in FETCH1, L=1
    lat = 1; stall_run = 0; req_log.delete();
    step(10'h010, 1'b0);
    step(10'h010, 1'b0);
    step(10'h020, 1'b0);
    run_until_hit(10'h020, 30);
    check("midchg_stall_cycles", 64'(stall_run), 64'd6);
    check("midchg_idata", idata_o, {mem[8'h08], mem[8'h09]});
    check_reqs("midchg_req", 4, 8'h04, 8'h05, 8'h08, 8'h09);

    // Reset in the 2nd FETCH0 cycle, L=3, stray ack afterwards
    lat = 3;
    step(10'h100, 1'b0);
    step(10'h100, 1'b0);
    step(10'h100, 1'b1);
    check("rstmid_req", 64'(mem_req_o), 64'd0);
    check("rstmid_stall", 64'(stall_o), 64'd1);
    check("rstmid_idata", idata_o, 64'd0);
    step(10'h100, 1'b1);
    stall_run = 0; req_log.delete();
    force_ack = 1'b1;
    step(10'h100, 1'b0);
    force_ack = 1'b0;
    step(10'h100, 1'b0);
    check("stray_ack_idata", idata_o, 64'd0);
    run_until_hit(10'h100, 40);
    check("rstmid_stall_cycles", 64'(stall_run), 64'd7);
    check("rstmid_fill", idata_o, {mem[8'h40], mem[8'h41]});

    // Randomized traffic
    ra = 10'h000;
    for (int c = 0; c < 600; c++) begin
      if (!mem_req_o) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 5))
          0:       ra = {8'hFF, 2'($urandom)};
          1:       ra = {8'hFE, 2'($urandom)};
          default: ra = {6'd0, 2'($urandom_range(0, 3)), 2'($urandom)};
        endcase
      end
      step(ra, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    run_until_hit(ra, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
